// File: rtl/control_seq.sv
// Multi-cycle control sequencer for the Hmmm CPU: fetches, decodes the IR and
// drives one micro-step of bus/register/ALU/PC/memory strobes per clock.
module control_seq #(
    parameter int WIDTH     = 16,
    parameter int REG_SEL_W = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    input  logic                 mem_ready,
    input  logic [WIDTH-1:0]     ir_data,
    input  logic                 flag_z,
    input  logic                 flag_n,
    output logic                 mar_in,
    output logic                 mdr_in,
    output logic                 mdr_out,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 pc_out,
    output logic                 pc_jump,
    output logic                 pc_increment,
    output logic                 tmp0_in,
    output logic                 tmp1_in,
    output logic                 alu_out,
    output logic                 flags_in,
    output logic [2:0]           alu_op,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 reg_in,
    output logic                 reg_out,
    output logic                 ir_in,
    output logic                 ir_out,
    output logic                 in_out,
    output logic                 out_in,
    output logic                 halt,
    output logic                 fault,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_F0    = 4'd1,
        ST_F1    = 4'd2,
        ST_F2    = 4'd3,
        ST_E0    = 4'd4,
        ST_E1    = 4'd5,
        ST_E2    = 4'd6,
        ST_HALT  = 4'd7,
        ST_FAULT = 4'd8
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     wait_cnt_r;
    logic                 halt_r;
    logic                 fault_r;
    logic                 busy_r;

    logic [3:0]           opcode_s;
    logic [3:0]           sub_s;
    logic [3:0]           alu_idx_s;
    logic [REG_SEL_W-1:0] rx_s;
    logic [REG_SEL_W-1:0] ry_s;
    logic [REG_SEL_W-1:0] rz_s;
    logic                 is_sys_s;
    logic                 is_loadn_s;
    logic                 is_storen_s;
    logic                 is_alu_s;
    logic                 is_jcond_s;
    logic                 cond_s;
    logic                 mem_wait_s;
    logic                 timeout_s;
    state_t               done_s;

    assign opcode_s    = ir_data[WIDTH-1 -: 4];
    assign sub_s       = ir_data[3:0];
    assign rx_s        = ir_data[WIDTH-5 -: REG_SEL_W];
    assign ry_s        = ir_data[WIDTH-5-REG_SEL_W -: REG_SEL_W];
    assign rz_s        = ir_data[WIDTH-5-2*REG_SEL_W -: REG_SEL_W];
    assign alu_idx_s   = opcode_s - 4'd6;
    assign is_sys_s    = (opcode_s == 4'd0);
    assign is_loadn_s  = (opcode_s == 4'd2);
    assign is_storen_s = (opcode_s == 4'd3);
    assign is_alu_s    = (opcode_s >= 4'd6) && (opcode_s <= 4'd10);
    assign is_jcond_s  = (opcode_s >= 4'd12);
    assign done_s      = run ? ST_F0 : ST_IDLE;

    // Jump condition selected by the low opcode bits: jeqzn, jnezn, jgtzn, jltzn
    always_comb begin
        cond_s = 1'b0;
        case (opcode_s[1:0])
            2'd0:    cond_s = flag_z;
            2'd1:    cond_s = !flag_z;
            2'd2:    cond_s = !flag_z && !flag_n;
            2'd3:    cond_s = flag_n;
            default: cond_s = 1'b0;
        endcase
    end

    assign mem_wait_s = (state_r == ST_F1)
                     || ((state_r == ST_E1) && is_loadn_s)
                     || ((state_r == ST_E2) && is_storen_s);
    assign timeout_s  = mem_wait_s && !mem_ready
                     && (wait_cnt_r == CNT_W'(WAIT_MAX - 1));

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run || step) begin
                    state_s = ST_F0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_F0: state_s = ST_F1;
            ST_F1: begin
                if (mem_ready) begin
                    state_s = ST_F2;
                end else if (timeout_s) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_F1;
                end
            end
            ST_F2: state_s = ST_E0;
            ST_E0: begin
                case (opcode_s)
                    4'd0: begin
                        if (sub_s == 4'd0) begin
                            state_s = ST_HALT;
                        end else begin
                            state_s = done_s;
                        end
                    end
                    4'd1, 4'd11:  state_s = done_s;
                    4'd4, 4'd5:   state_s = ST_FAULT;
                    default:      state_s = ST_E1;
                endcase
            end
            ST_E1: begin
                if (!is_loadn_s || mem_ready) begin
                    state_s = ST_E2;
                end else if (timeout_s) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_E1;
                end
            end
            ST_E2: begin
                if (!is_storen_s || mem_ready) begin
                    state_s = done_s;
                end else if (timeout_s) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_E2;
                end
            end
            ST_HALT:  state_s = ST_HALT;
            ST_FAULT: state_s = ST_FAULT;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Memory wait counter; any exit from a wait state leaves it cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= '0;
        end else if (mem_wait_s && !mem_ready && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Status flags registered alongside the state they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_r  <= 1'b0;
            fault_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            halt_r  <= (state_s == ST_HALT);
            fault_r <= (state_s == ST_FAULT);
            busy_r  <= (state_s != ST_IDLE) && (state_s != ST_HALT)
                    && (state_s != ST_FAULT);
        end
    end

    assign halt  = halt_r;
    assign fault = fault_r;
    assign busy  = busy_r;

    // Per-state strobe decode; execute steps read the freshly loaded IR
    always_comb begin
        mar_in       = 1'b0;
        mdr_in       = 1'b0;
        mdr_out      = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        pc_out       = 1'b0;
        pc_jump      = 1'b0;
        pc_increment = 1'b0;
        tmp0_in      = 1'b0;
        tmp1_in      = 1'b0;
        alu_out      = 1'b0;
        flags_in     = 1'b0;
        alu_op       = 3'd0;
        reg_sel      = '0;
        reg_in       = 1'b0;
        reg_out      = 1'b0;
        ir_in        = 1'b0;
        ir_out       = 1'b0;
        in_out       = 1'b0;
        out_in       = 1'b0;
        case (state_r)
            ST_F0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
            end
            ST_F1: begin
                mem_rd = 1'b1;
                mdr_in = mem_ready;
            end
            ST_F2: begin
                mdr_out      = 1'b1;
                ir_in        = 1'b1;
                pc_increment = 1'b1;
            end
            ST_E0: begin
                if (is_sys_s) begin
                    case (sub_s)
                        4'd1: begin
                            in_out  = 1'b1;
                            reg_in  = 1'b1;
                            reg_sel = rx_s;
                        end
                        4'd2: begin
                            reg_out = 1'b1;
                            reg_sel = rx_s;
                            out_in  = 1'b1;
                        end
                        4'd3: begin
                            reg_out = 1'b1;
                            reg_sel = rx_s;
                            pc_jump = 1'b1;
                        end
                        default: reg_sel = '0;
                    endcase
                end else if (opcode_s == 4'd1) begin
                    ir_out  = 1'b1;
                    reg_in  = 1'b1;
                    reg_sel = rx_s;
                end else if (is_loadn_s || is_storen_s) begin
                    ir_out = 1'b1;
                    mar_in = 1'b1;
                end else if (is_alu_s) begin
                    reg_out = 1'b1;
                    reg_sel = ry_s;
                    tmp0_in = 1'b1;
                end else if (opcode_s == 4'd11) begin
                    ir_out  = 1'b1;
                    pc_jump = 1'b1;
                end else if (is_jcond_s) begin
                    reg_out = 1'b1;
                    reg_sel = rx_s;
                    tmp0_in = 1'b1;
                end else begin
                    reg_sel = '0;
                end
            end
            ST_E1: begin
                if (is_loadn_s) begin
                    mem_rd = 1'b1;
                    mdr_in = mem_ready;
                end else if (is_storen_s) begin
                    reg_out = 1'b1;
                    reg_sel = rx_s;
                    mdr_in  = 1'b1;
                end else if (is_alu_s) begin
                    reg_out = 1'b1;
                    reg_sel = rz_s;
                    tmp1_in = 1'b1;
                end else if (is_jcond_s) begin
                    alu_op   = 3'd5;
                    flags_in = 1'b1;
                end else begin
                    reg_sel = '0;
                end
            end
            ST_E2: begin
                if (is_loadn_s) begin
                    mdr_out = 1'b1;
                    reg_in  = 1'b1;
                    reg_sel = rx_s;
                end else if (is_storen_s) begin
                    mem_wr = 1'b1;
                end else if (is_alu_s) begin
                    alu_out  = 1'b1;
                    alu_op   = alu_idx_s[2:0];
                    reg_in   = 1'b1;
                    reg_sel  = rx_s;
                    flags_in = 1'b1;
                end else if (is_jcond_s && cond_s) begin
                    ir_out  = 1'b1;
                    pc_jump = 1'b1;
                end else begin
                    reg_sel = '0;
                end
            end
            default: reg_sel = '0;
        endcase
    end

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: expected per-cycle strobe vectors are queued
// with the stimulus for that cycle and compared as the sequencer steps.
module tb_control_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b1;
    logic        step = 1'b0;
    logic        mem_ready = 1'b1;
    logic [15:0] ir_data = 16'h0000;
    logic        flag_z = 1'b0;
    logic        flag_n = 1'b0;
    logic        mar_in, mdr_in, mdr_out, mem_rd, mem_wr;
    logic        pc_out, pc_jump, pc_increment;
    logic        tmp0_in, tmp1_in, alu_out, flags_in;
    logic [2:0]  alu_op;
    logic [3:0]  reg_sel;
    logic        reg_in, reg_out, ir_in, ir_out, in_out, out_in;
    logic        halt, fault, busy;

    control_seq #(.WIDTH(16), .REG_SEL_W(4), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .mem_ready(mem_ready),
        .ir_data(ir_data), .flag_z(flag_z), .flag_n(flag_n),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .pc_out(pc_out), .pc_jump(pc_jump), .pc_increment(pc_increment),
        .tmp0_in(tmp0_in), .tmp1_in(tmp1_in), .alu_out(alu_out),
        .flags_in(flags_in), .alu_op(alu_op), .reg_sel(reg_sel),
        .reg_in(reg_in), .reg_out(reg_out), .ir_in(ir_in), .ir_out(ir_out),
        .in_out(in_out), .out_in(out_in),
        .halt(halt), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [27:0] MAR  = 28'd1 << 27;
    localparam logic [27:0] MDRI = 28'd1 << 26;
    localparam logic [27:0] MDRO = 28'd1 << 25;
    localparam logic [27:0] MRD  = 28'd1 << 24;
    localparam logic [27:0] MWR  = 28'd1 << 23;
    localparam logic [27:0] PCO  = 28'd1 << 22;
    localparam logic [27:0] PCJ  = 28'd1 << 21;
    localparam logic [27:0] PCI  = 28'd1 << 20;
    localparam logic [27:0] T0   = 28'd1 << 19;
    localparam logic [27:0] T1   = 28'd1 << 18;
    localparam logic [27:0] ALUO = 28'd1 << 17;
    localparam logic [27:0] FI   = 28'd1 << 16;
    localparam logic [27:0] RI   = 28'd1 << 8;
    localparam logic [27:0] RO   = 28'd1 << 7;
    localparam logic [27:0] IRI  = 28'd1 << 6;
    localparam logic [27:0] IRO  = 28'd1 << 5;
    localparam logic [27:0] INO  = 28'd1 << 4;
    localparam logic [27:0] OUTI = 28'd1 << 3;
    localparam logic [27:0] HLT  = 28'd1 << 2;
    localparam logic [27:0] FLT  = 28'd1 << 1;
    localparam logic [27:0] BSY  = 28'd1;

    logic [27:0] outs_s;
    assign outs_s = {mar_in, mdr_in, mdr_out, mem_rd, mem_wr, pc_out, pc_jump,
                     pc_increment, tmp0_in, tmp1_in, alu_out, flags_in, alu_op,
                     reg_sel, reg_in, reg_out, ir_in, ir_out, in_out, out_in,
                     halt, fault, busy};

    typedef struct packed {
        logic [15:0] ir;
        logic        rdy;
        logic        fz;
        logic        fn;
        logic        run;
        logic        step;
        logic [27:0] exp;
    } cyc_t;

    cyc_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    string       cur_tag = "";
    logic [15:0] cur_ir = 16'h0000;
    logic        cur_fz = 1'b0;
    logic        cur_fn = 1'b0;
    logic        cur_run = 1'b1;
    logic        cur_step = 1'b0;

    function automatic logic [27:0] sel(input int n);
        return 28'(n) << 9;
    endfunction

    function automatic logic [27:0] op(input int n);
        return 28'(n) << 13;
    endfunction

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%07h want=%07h", tag, got, want);
        end
    endtask

    task automatic push(input logic [27:0] e, input logic rdy = 1'b1);
        cyc_t c;
        c.ir = cur_ir; c.rdy = rdy; c.fz = cur_fz; c.fn = cur_fn;
        c.run = cur_run; c.step = cur_step; c.exp = e;
        sb_q.push_back(c);
    endtask

    task automatic push_fetch(input int waits);
        push(MAR | PCO | BSY);
        for (int k = 0; k < waits; k++) push(MRD | BSY, 1'b0);
        push(MRD | MDRI | BSY);
        push(MDRO | IRI | PCI | BSY);
    endtask

    task automatic start(input string tag, input logic [15:0] ir,
                         input logic fz = 1'b0, input logic fn = 1'b0);
        cur_tag = tag; cur_ir = ir; cur_fz = fz; cur_fn = fn;
    endtask

    // Each queued entry covers one clock: drive its inputs, then compare
    task automatic drain();
        cyc_t c;
        int   i = 0;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            @(posedge clk);
            #1;
            ir_data = c.ir; mem_ready = c.rdy; flag_z = c.fz; flag_n = c.fn;
            run = c.run; step = c.step;
            #1;
            chk($sformatf("%s_c%0d", cur_tag, i), outs_s, c.exp);
            i++;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk(tag, outs_s, 28'd0);
        run = 1'b1; step = 1'b0; cur_run = 1'b1; cur_step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #12;
        chk("reset_outs", outs_s, 28'd0);
        @(negedge clk);
        rst = 1'b1;

        start("setn", 16'h112A);
        push_fetch(0); push(IRO | RI | sel(1) | BSY); drain();

        start("add", 16'h6123);
        push_fetch(0);
        push(RO | sel(2) | T0 | BSY); push(RO | sel(3) | T1 | BSY);
        push(ALUO | op(0) | sel(1) | RI | FI | BSY); drain();

        start("mod", 16'hA456);
        push_fetch(0);
        push(RO | sel(5) | T0 | BSY); push(RO | sel(6) | T1 | BSY);
        push(ALUO | op(4) | sel(4) | RI | FI | BSY); drain();

        start("loadn_wait", 16'h2500);
        push_fetch(3);
        push(IRO | MAR | BSY); push(MRD | MDRI | BSY);
        push(MDRO | RI | sel(5) | BSY); drain();

        start("storen", 16'h3400);
        push_fetch(0);
        push(IRO | MAR | BSY); push(RO | sel(4) | MDRI | BSY);
        push(MWR | BSY, 1'b0); push(MWR | BSY); drain();

        start("jeqz_t", 16'hC305, 1'b1, 1'b0);
        push_fetch(0);
        push(RO | sel(3) | T0 | BSY); push(op(5) | FI | BSY); push(IRO | PCJ | BSY); drain();
        start("jeqz_n", 16'hC305, 1'b0, 1'b0);
        push_fetch(0);
        push(RO | sel(3) | T0 | BSY); push(op(5) | FI | BSY); push(BSY); drain();
        start("jgtz_t", 16'hE305, 1'b0, 1'b0);
        push_fetch(0);
        push(RO | sel(3) | T0 | BSY); push(op(5) | FI | BSY); push(IRO | PCJ | BSY); drain();
        start("jgtz_n", 16'hE305, 1'b0, 1'b1);
        push_fetch(0);
        push(RO | sel(3) | T0 | BSY); push(op(5) | FI | BSY); push(BSY); drain();

        start("jumpn", 16'hB020); push_fetch(0); push(IRO | PCJ | BSY); drain();
        start("read", 16'h0301);  push_fetch(0); push(INO | RI | sel(3) | BSY); drain();
        start("write", 16'h0302); push_fetch(0); push(RO | sel(3) | OUTI | BSY); drain();
        start("jumpr", 16'h0303); push_fetch(0); push(RO | sel(3) | PCJ | BSY); drain();
        start("nop", 16'h0307);   push_fetch(0); push(BSY); drain();

        // Drop to single-step: this instruction finishes into IDLE
        start("step_a", 16'h1705); cur_run = 1'b0;
        push_fetch(0); push(IRO | RI | sel(7) | BSY);
        push(28'd0); push(28'd0); push(28'd0);
        cur_ir = 16'h1203; cur_step = 1'b1; push(28'd0); cur_step = 1'b0;
        push_fetch(0); push(IRO | RI | sel(2) | BSY);
        push(28'd0); push(28'd0); drain();

        start("halt", 16'h0000);
        cur_step = 1'b1; push(28'd0); cur_step = 1'b0;
        push_fetch(0); push(BSY); push(HLT);
        cur_step = 1'b1; push(HLT); push(HLT); cur_step = 1'b0; push(HLT); push(HLT);
        drain();

        do_reset("rst_halt");
        start("rsvd", 16'h4000);
        push_fetch(0); push(BSY); push(FLT); push(FLT); drain();

        do_reset("rst_rsvd");
        start("timeout", 16'h112A);
        push(MAR | PCO | BSY);
        for (int k = 0; k < 15; k++) push(MRD | BSY, 1'b0);
        for (int k = 0; k < 3; k++) push(FLT, 1'b0);
        drain();

        do_reset("rst_fault");
        start("st_abort", 16'h3400);
        push_fetch(0); push(IRO | MAR | BSY); push(RO | sel(4) | MDRI | BSY); drain();
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst", outs_s, 28'd0);
        @(negedge clk);
        rst = 1'b1;
        start("after_rst", 16'h112A);
        push(MAR | PCO | BSY); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
